// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the in-order pipeline. Owns the program counter,
// issues word requests to instruction memory over a valid/ready channel and
// collects the in-order, variable-latency responses into a small queue that
// feeds the fetch/decode pipeline register. A redirect from execute flushes
// the queue and turns every still-outstanding response into a drop.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   StallFetch                 hold the queue head (hazard unit)
//   ProgramCounterSourceExec   redirect request from execute
//   ProgramCounterTargetExec   redirect target PC
//   InstrMemReqValid/Addr      request channel to instruction memory
//   InstrMemReqReady           memory accepts the request this cycle
//   InstrMemRespValid/Data     in-order response channel
//   InstructionFetch           instruction at queue head (0 when empty)
//   ProgramCounterFetch        PC of queue head (0 when empty)
//   ProgramCounterPlus4Fetch   head PC + 4 (0 when empty)
//   InstructionValidFetch      queue non-empty
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] ResetVector = 32'h0000_0000,
    parameter int          QueueDepth  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallFetch,
    input  logic        ProgramCounterSourceExec,
    input  logic [31:0] ProgramCounterTargetExec,
    output logic        InstrMemReqValid,
    output logic [31:0] InstrMemReqAddr,
    input  logic        InstrMemReqReady,
    input  logic        InstrMemRespValid,
    input  logic [31:0] InstrMemRespData,
    output logic [31:0] InstructionFetch,
    output logic [31:0] ProgramCounterFetch,
    output logic [31:0] ProgramCounterPlus4Fetch,
    output logic        InstructionValidFetch
);

    localparam int CW = $clog2(QueueDepth + 1);
    localparam int IW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;

    // Control state
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] q_count;
    logic [IW-1:0] head_ptr;
    logic [IW-1:0] tail_ptr;

    // Queue storage (data only, never reset; validity comes from q_count)
    logic [31:0]   q_instr [QueueDepth];
    logic [31:0]   q_pc    [QueueDepth];

    logic          redirect;
    logic          accept;
    logic          resp_eff;
    logic          push;
    logic          pop;
    logic [CW:0]   in_use;
    logic [CW-1:0] out_after_resp;

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        return (p == IW'(QueueDepth - 1)) ? '0 : p + IW'(1);
    endfunction

    assign redirect = ProgramCounterSourceExec;

    // Credit uses registered occupancy only, so a same-cycle pop or response
    // never creates a combinational path into the request valid.
    assign in_use           = {1'b0, outstanding} + {1'b0, q_count};
    assign InstrMemReqValid = !reset && !redirect && (in_use < (CW+1)'(QueueDepth));
    assign InstrMemReqAddr  = fetch_pc;

    assign accept   = InstrMemReqValid && InstrMemReqReady;
    // A response with nothing outstanding is a protocol violation: ignore it.
    assign resp_eff = InstrMemRespValid && (outstanding != '0);
    assign push     = resp_eff && (drop_cnt == '0) && !redirect;
    assign pop      = (q_count != '0) && !StallFetch && !redirect;

    assign out_after_resp = outstanding - CW'(resp_eff);

    // Head outputs are purely registered state; zero when the queue is empty.
    assign InstructionValidFetch    = (q_count != '0);
    assign InstructionFetch         = InstructionValidFetch ? q_instr[head_ptr] : 32'h0;
    assign ProgramCounterFetch      = InstructionValidFetch ? q_pc[head_ptr]    : 32'h0;
    assign ProgramCounterPlus4Fetch = InstructionValidFetch ? q_pc[head_ptr] + 32'd4 : 32'h0;

    // Control state update
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= ResetVector;
            resp_pc     <= ResetVector;
            outstanding <= '0;
            drop_cnt    <= '0;
            q_count     <= '0;
            head_ptr    <= '0;
            tail_ptr    <= '0;
        end else if (redirect) begin
            // Everything still in flight after this cycle belongs to the
            // squashed path and must be discarded on return.
            fetch_pc    <= ProgramCounterTargetExec;
            resp_pc     <= ProgramCounterTargetExec;
            outstanding <= out_after_resp;
            drop_cnt    <= out_after_resp;
            q_count     <= '0;
            head_ptr    <= '0;
            tail_ptr    <= '0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= out_after_resp + CW'(accept);
            if (resp_eff && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
                tail_ptr <= next_ptr(tail_ptr);
                resp_pc  <= resp_pc + 32'd4;
            end
            if (pop) begin
                head_ptr <= next_ptr(head_ptr);
            end
            q_count <= q_count + CW'(push) - CW'(pop);
        end
    end

    // Queue write
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail_ptr] <= InstrMemRespData;
            q_pc[tail_ptr]    <= resp_pc;
        end
    end

endmodule
